// File: rtl/carry_save_normalizer.sv
// -----------------------------------------------------------------------------
// carry_save_normalizer
//   Resolves the per-column carry/sum pairs from the multiply stage into a
//   normalized product of NUM_COLS words of WORD_LEN bits. Carries ripple from
//   the least significant column upwards, COLS_PER_CYCLE columns per clock.
//   One operand set is held at a time; both sides use valid/ready.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   Cin/Sin hold a valid column set
//   in_ready   block can accept a new column set (only while idle)
//   Cin, Sin   NUM_COLS column values of OUT_BIT_LEN bits, column i at
//              bits [i*OUT_BIT_LEN +: OUT_BIT_LEN]
//   out_valid  R/carry_out hold a finished result
//   out_ready  downstream accepts the result
//   R          NUM_COLS normalized words, word i at [i*WORD_LEN +: WORD_LEN]
//   carry_out  carry leaving the top column
// -----------------------------------------------------------------------------
module carry_save_normalizer #(
    parameter int NUM_ELEMENTS   = 33,
    parameter int WORD_LEN       = 16,
    parameter int OUT_BIT_LEN    = 25,
    parameter int COLS_PER_CYCLE = 2,
    parameter int NUM_COLS       = 2 * NUM_ELEMENTS,
    parameter int CARRY_BIT_LEN  = OUT_BIT_LEN - WORD_LEN + 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [OUT_BIT_LEN*NUM_COLS-1:0]   Cin,
    input  logic [OUT_BIT_LEN*NUM_COLS-1:0]   Sin,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WORD_LEN*NUM_COLS-1:0]      R,
    output logic [CARRY_BIT_LEN-1:0]          carry_out
);

    localparam int IDX_W = $clog2(NUM_COLS + 1);
    localparam int SUM_W = CARRY_BIT_LEN + WORD_LEN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic                       in_ready_r;
    logic                       in_ready_nxt_s;
    logic                       out_valid_r;
    logic                       out_valid_nxt_s;
    logic [IDX_W-1:0]           idx_r;
    logic [CARRY_BIT_LEN-1:0]   carry_r;
    logic [CARRY_BIT_LEN-1:0]   carry_out_r;
    logic [CARRY_BIT_LEN-1:0]   carry_nxt_s;
    logic                       last_step_s;
    logic                       accept_s;

    logic [OUT_BIT_LEN-1:0]     cin_s  [NUM_COLS];
    logic [OUT_BIT_LEN-1:0]     sin_s  [NUM_COLS];
    logic [OUT_BIT_LEN-1:0]     cin_r  [NUM_COLS];
    logic [OUT_BIT_LEN-1:0]     sin_r  [NUM_COLS];
    logic [WORD_LEN-1:0]        r_r    [NUM_COLS];
    logic [IDX_W-1:0]           col_s  [COLS_PER_CYCLE];
    logic [WORD_LEN-1:0]        word_s [COLS_PER_CYCLE];

    // Unpack the flat input buses and pack the result words.
    for (genvar g = 0; g < NUM_COLS; g++) begin : g_cols
        assign cin_s[g] = Cin[g*OUT_BIT_LEN +: OUT_BIT_LEN];
        assign sin_s[g] = Sin[g*OUT_BIT_LEN +: OUT_BIT_LEN];
        assign R[g*WORD_LEN +: WORD_LEN] = r_r[g];
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign carry_out   = carry_out_r;
    assign accept_s    = in_valid & in_ready_r;
    assign last_step_s = (idx_r == IDX_W'(NUM_COLS - COLS_PER_CYCLE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_step_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs follow the state being entered so they can be
    // registered without adding a cycle of latency.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        if (state_nxt_s == ST_IDLE) begin
            in_ready_nxt_s = 1'b1;
        end else begin
            in_ready_nxt_s = 1'b0;
        end
        if (state_nxt_s == ST_DONE) begin
            out_valid_nxt_s = 1'b1;
        end else begin
            out_valid_nxt_s = 1'b0;
        end
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // Column adders for this cycle, chained so the carry of column idx+k
    // feeds column idx+k+1 within the same clock.
    always_comb begin
        logic [CARRY_BIT_LEN-1:0] chain_v;
        logic [SUM_W-1:0]         t_v;
        chain_v = carry_r;
        t_v     = {SUM_W{1'b0}};
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_s[k]  = idx_r + IDX_W'(k);
            t_v       = SUM_W'(cin_r[col_s[k]]) + SUM_W'(sin_r[col_s[k]])
                      + SUM_W'(chain_v);
            word_s[k] = t_v[WORD_LEN-1:0];
            chain_v   = t_v[SUM_W-1:WORD_LEN];
        end
        carry_nxt_s = chain_v;
    end

    // Operand capture, column walk and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                cin_r[i] <= {OUT_BIT_LEN{1'b0}};
                sin_r[i] <= {OUT_BIT_LEN{1'b0}};
                r_r[i]   <= {WORD_LEN{1'b0}};
            end
            idx_r       <= {IDX_W{1'b0}};
            carry_r     <= {CARRY_BIT_LEN{1'b0}};
            carry_out_r <= {CARRY_BIT_LEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        for (int i = 0; i < NUM_COLS; i++) begin
                            cin_r[i] <= cin_s[i];
                            sin_r[i] <= sin_s[i];
                        end
                        idx_r   <= {IDX_W{1'b0}};
                        carry_r <= {CARRY_BIT_LEN{1'b0}};
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                        r_r[col_s[k]] <= word_s[k];
                    end
                    carry_r <= carry_nxt_s;
                    idx_r   <= idx_r + IDX_W'(COLS_PER_CYCLE);
                    if (last_step_s) begin
                        carry_out_r <= carry_nxt_s;
                    end else begin
                        carry_out_r <= carry_out_r;
                    end
                end
                default: begin
                    // DONE: results held until the next run overwrites them.
                    idx_r <= idx_r;
                end
            endcase
        end
    end

endmodule
